// File: rtl/chacha_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chacha_pkg
//  Description : Shared types and constants for the ChaCha block-counter
//                generator and its neighbours.
//                  ctr_state_t        - counter generator state encoding
//                  CHACHA_CTR_W_IETF  - 32-bit block counter (RFC 8439)
//                  CHACHA_CTR_W_ORIG  - 64-bit block counter (original ChaCha)
//  Revision    : 1.0 - initial release
// ============================================================================
package chacha_pkg;

    typedef enum logic [1:0] {
        CTR_IDLE = 2'd0,
        CTR_RUN  = 2'd1,
        CTR_EXH  = 2'd2
    } ctr_state_t;

    localparam int CHACHA_CTR_W_IETF = 32;
    localparam int CHACHA_CTR_W_ORIG = 64;

endpackage : chacha_pkg
`default_nettype wire

// File: rtl/chacha_ctr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : chacha_ctr_gen_if
//  Description : Valid/ready counter-group channel from the counter generator
//                to the ChaCha block-function core(s).
//                  ctr_valid  - producer has a legal, unissued group
//                  ctr_ready  - consumer accepts the group this cycle
//                  ctr_lanes  - LANES counters, lane i at [i*CTR_W +: CTR_W]
//                Modports: master (generator side), slave (core side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface chacha_ctr_gen_if #(
    parameter int CTR_W = 32,
    parameter int LANES = 1
);
    logic                   ctr_valid;
    logic                   ctr_ready;
    logic [LANES*CTR_W-1:0] ctr_lanes;

    modport master (
        output ctr_valid,
        output ctr_lanes,
        input  ctr_ready
    );

    modport slave (
        input  ctr_valid,
        input  ctr_lanes,
        output ctr_ready
    );
endinterface : chacha_ctr_gen_if
`default_nettype wire

// File: rtl/chacha_ctr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : chacha_ctr_gen
//  Description : ChaCha block-counter generator. Issues groups of LANES
//                consecutive block counters (base, base+1, ...) over a
//                valid/ready channel and refuses to reuse a counter: in
//                WRAP_MODE=0 it stops and flags exhaustion at the end of the
//                counter space, in WRAP_MODE=1 it wraps modulo 2^CTR_W.
//  Ports       : clk           - clock
//                reset         - synchronous active-high reset
//                enable        - 0 pauses issue, state held
//                load_en       - load load_value as new base (new session)
//                load_value    - initial block counter
//                ctr           - counter channel (master modport)
//                exhausted     - counter space used up, sticky until load
//                blocks_issued - counters issued since last load (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module chacha_ctr_gen
    import chacha_pkg::*;
#(
    parameter int CTR_W     = 32,
    parameter int LANES     = 1,
    parameter int WRAP_MODE = 0,
    parameter int CNT_W     = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             enable,
    input  wire logic             load_en,
    input  wire logic [CTR_W-1:0] load_value,
    chacha_ctr_gen_if.master      ctr,
    output logic                  exhausted,
    output logic [CNT_W-1:0]      blocks_issued
);

    // ------------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------------
    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_chk_lanes
            $error("chacha_ctr_gen: LANES must be 1, 2, 4 or 8");
        end
        if (!(CTR_W == CHACHA_CTR_W_IETF || CTR_W == CHACHA_CTR_W_ORIG)) begin : g_chk_ctr_w
            $error("chacha_ctr_gen: CTR_W must be 32 or 64");
        end
    endgenerate

    // Highest base whose whole group still fits in the counter space:
    // 2^CTR_W - LANES. Held in CTR_W+1 bits so base+LANES cannot overflow
    // silently when deciding legality.
    localparam logic [CTR_W:0] C_SPACE     = {1'b1, {CTR_W{1'b0}}};
    localparam logic [CTR_W:0] C_LAST_BASE = C_SPACE - (CTR_W+1)'(LANES);
    localparam logic [CTR_W:0] C_LANES_EXT = (CTR_W+1)'(LANES);
    localparam logic [CNT_W:0] C_LANES_CNT = (CNT_W+1)'(LANES);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    ctr_state_t        r_state;
    ctr_state_t        w_state_nxt;
    logic [CTR_W-1:0]  r_base;
    logic [CNT_W-1:0]  r_blocks;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    logic              w_xfer;
    logic [CTR_W:0]    w_next_base_ext;
    logic              w_next_legal;
    logic              w_load_legal;
    logic [CNT_W:0]    w_blk_sum;
    logic [CNT_W-1:0]  w_blk_sat;

    assign w_xfer          = ctr.ctr_valid & ctr.ctr_ready;
    assign w_next_base_ext = {1'b0, r_base} + C_LANES_EXT;
    assign w_next_legal    = (w_next_base_ext <= C_LAST_BASE);
    assign w_load_legal    = ({1'b0, load_value} <= C_LAST_BASE);

    // Saturating statistic: a carry out of CNT_W bits clamps to all ones.
    assign w_blk_sum = {1'b0, r_blocks} + C_LANES_CNT;
    assign w_blk_sat = w_blk_sum[CNT_W] ? {CNT_W{1'b1}} : w_blk_sum[CNT_W-1:0];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CTR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (load_en) begin
            // A load always starts a fresh session; only an out-of-space
            // start value in stop mode lands directly in exhaustion.
            if ((WRAP_MODE != 0) || w_load_legal) begin
                w_state_nxt = CTR_RUN;
            end else begin
                w_state_nxt = CTR_EXH;
            end
        end else if (w_xfer && (WRAP_MODE == 0) && !w_next_legal) begin
            w_state_nxt = CTR_EXH;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (registered state only, no path from ctr_ready)
    // ------------------------------------------------------------------------
    always_comb begin
        ctr.ctr_valid = (r_state == CTR_RUN) & enable;
        exhausted     = (WRAP_MODE == 0) && (r_state == CTR_EXH);
    end

    // ------------------------------------------------------------------------
    // Base counter and issue statistic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base   <= '0;
            r_blocks <= '0;
        end else if (load_en) begin
            // Load wins over a coincident transfer: the consumer still takes
            // the old group, but its count is dropped with the old session.
            r_base   <= load_value;
            r_blocks <= '0;
        end else if (w_xfer) begin
            // In stop mode the base freezes on the last legal group so the
            // lanes never show a reused counter.
            if ((WRAP_MODE != 0) || w_next_legal) begin
                r_base <= w_next_base_ext[CTR_W-1:0];
            end
            r_blocks <= w_blk_sat;
        end
    end

    assign blocks_issued = r_blocks;

    // ------------------------------------------------------------------------
    // Lane adders: lane i carries base+i, wrapping modulo 2^CTR_W
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            localparam logic [CTR_W-1:0] C_OFS = CTR_W'(i);
            assign ctr.ctr_lanes[i*CTR_W +: CTR_W] = r_base + C_OFS;
        end
    endgenerate

endmodule : chacha_ctr_gen
`default_nettype wire
